// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the decode stage.
// The master modport is the fetch stage's view. FETCH_MISALIGN_TRAP_EN adds
// the misaligned flag.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  PCsrc;
    logic [ADDR_WIDTH-1:0] ImmOp;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  misaligned;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output instr, instr_pc, instr_valid,
        input  instr_ready, PCsrc, ImmOp
`ifdef FETCH_MISALIGN_TRAP_EN
        , output misaligned
`endif
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  instr, instr_pc, instr_valid,
        output instr_ready, PCsrc, ImmOp
`ifdef FETCH_MISALIGN_TRAP_EN
        , input misaligned
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/ready handshake and presents it to decode with valid/ready. The next
// PC is chosen from PCsrc/ImmOp on the accept cycle.
// Optional macro FETCH_MISALIGN_TRAP_EN: an unaligned next PC parks the
// stage in TRAP (misaligned=1) until reset; without it the low PC bits are
// cleared.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic         clk,
    input logic         rst_n,
    fetch_unit_if.master bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_sum;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] instr_pc_q;
    logic                  instr_valid_q;
    logic                  imem_req_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  misaligned_q;
`endif

    // Next-PC adder; wraps modulo 2^ADDR_WIDTH, ImmOp is two's complement.
    assign pc_sum = pc + (bus.PCsrc ? bus.ImmOp : ADDR_WIDTH'(4));

`ifdef FETCH_MISALIGN_TRAP_EN
    assign pc_next = pc_sum;
`else
    assign pc_next = pc_sum & ~ADDR_WIDTH'(3);
`endif

    // Address comes straight from the PC register, so it is stable while waiting.
    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misaligned  = misaligned_q;
`endif

    // Fetch FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH, WAIT: begin
                    if (bus.imem_ready) begin
                        instr_q       <= bus.imem_rdata;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state         <= HOLD;
                    end else begin
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        pc            <= pc_next;
                        instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (pc_next[1:0] != 2'b00) begin
                            misaligned_q <= 1'b1;
                            state        <= TRAP;
                        end else begin
                            imem_req_q <= 1'b1;
                            state      <= FETCH;
                        end
`else
                        imem_req_q    <= 1'b1;
                        state         <= FETCH;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                // Parked until reset; PC keeps the offending value.
                TRAP: begin
                    state <= TRAP;
                end
`endif
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control unit.
- Holds the program counter and requests instruction words from instruction memory over a req/ready handshake.
- Presents each fetched instruction to the decode stage with a valid/ready handshake.
- Computes the next PC from the decode stage's PCsrc and ImmOp branch inputs at the moment the instruction is accepted.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 0, PC loaded on reset (must be 4-byte aligned).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_WIDTH  fetch address; valid while imem_req=1.
- imem_ready  in  1  memory response valid; imem_rdata is valid this cycle.
- imem_rdata  in  DATA_WIDTH  instruction word from memory.
- instr  out  DATA_WIDTH  registered instruction to the control unit.
- instr_pc  out  ADDR_WIDTH  PC of the presented instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode stage accepts instr this cycle.
- PCsrc  in  1  1 = take branch; sampled only on the accept cycle.
- ImmOp  in  ADDR_WIDTH  sign-extended branch offset; sampled only on the accept cycle.

Behaviour:
- Reset: when rst_n=0 at a clock edge, the following take effect on the next cycle:
  - state=FETCH, pc=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0.
  - imem_req=1, with imem_addr=RESET_PC.
- Reset mid-operation: any outstanding response is discarded.
  - Instruction memory shares rst_n and drops outstanding requests.
  - A response in the first post-reset cycle is treated as the response to the RESET_PC request.
- FSM with states FETCH, WAIT, HOLD:
  - FETCH:
    - Outputs: imem_req=1, imem_addr=pc.
    - If imem_ready: capture instr<=imem_rdata and instr_pc<=pc, then go to HOLD (zero-wait memory).
    - Otherwise go to WAIT.
  - WAIT:
    - Outputs: imem_req=1, imem_addr=pc (held stable).
    - On imem_ready: capture as in FETCH, then go to HOLD.
    - No timeout.
  - HOLD:
    - Outputs: imem_req=0, instr_valid=1.
    - instr and instr_pc stay stable until accepted.
    - On instr_ready (accept): pc <= PCsrc ? pc+ImmOp : pc+4; instr_valid falls next cycle; go to FETCH.
- Handshake rules:
  - imem_ready is ignored while imem_req=0.
  - instr_ready is ignored while instr_valid=0.
  - Only one memory request is outstanding at a time.
- Latency and throughput:
  - Zero-wait memory with decode always ready gives one instruction per 2 cycles.
  - Each memory wait cycle adds 1 cycle.
  - Each cycle instr_ready is held low in HOLD adds 1 cycle.
- Arithmetic: PC additions are modulo 2^ADDR_WIDTH (wrap silently). ImmOp is treated as two's complement.
- Alignment (feature off): next pc bits [1:0] are forced to 0.
- PCsrc/ImmOp outside the accept cycle have no effect.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds an output port misaligned (1 bit, reset 0) and a fourth state, TRAP.
  - If the computed next pc has bits [1:0]!=0 on accept, the FSM goes to TRAP.
  - TRAP behaviour: misaligned=1; pc holds the unaligned value; imem_req=0; instr_valid=0.
  - TRAP is left only by rst_n=0.
- Not defined:
  - No port and no TRAP state.
  - Next pc bits [1:0] are forced to 0.

Test Plan:
- Reset release, zero-wait memory (imem_ready=1 always), instr_ready=1, PCsrc=0 -> imem_addr sequence 0x0,0x4,0x8,0xC, one new word every 2 cycles, with instr_pc matching each word's address.
- Memory wait: imem_ready low for 3 cycles at addr 0x4 -> imem_addr held at 0x4 with req=1 for 4 cycles; instr_valid rises the cycle after ready; instr equals imem_rdata.
- Decode stall: instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc/instr_valid stable, imem_req=0, pc not advanced; next fetch follows the accept.
- Branch: accept at pc=0x10 with PCsrc=1, ImmOp=0xFFFFFFF8 (-8) -> next imem_addr=0x08; with ImmOp=0x20 -> 0x30. PCsrc=1 while not accepting -> no effect.
- Wrap and reset: pc=0xFFFFFFFC accept with PCsrc=0 -> next addr 0x0. Assert rst_n=0 during WAIT -> next cycle FETCH at RESET_PC with instr_valid=0.
- Misalign (with FETCH_MISALIGN_TRAP_EN): accept at 0x20 with PCsrc=1, ImmOp=0x2 -> misaligned=1, imem_req=0 until reset. Without the macro -> next addr 0x20.
